// File: rtl/tracer_host.sv
// tracer_host: feeds Q6.10 operands to the nibble-serial reciprocal tracer; result 6 cycles after frame start (7 with TRACER_HOST_SYNC_EN).
// One-deep pending buffer gives in_ready backpressure; results have no backpressure and must be taken on the res_valid pulse.
module tracer_host (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_abs,
   output logic        res_valid,
   output logic [15:0] res_data,
   output logic        t_reset,
   output logic        t_abs,
   output logic [3:0]  t_data,
   input  logic [7:0]  t_in
);

   logic [2:0]  phase;
   logic        pend;
   logic        pend_abs;
   logic [15:0] pend_data;
   logic        active;
   logic [15:0] shift;
   logic [7:0]  lo;
   logic [7:0]  hi;
   logic        done;
   logic        frame_start;

   assign frame_start = (phase == 3'd5);
   assign in_ready    = !pend;
   assign t_reset     = reset;
   assign res_valid   = done;
   assign res_data    = {hi, lo};

   // Phase free-runs in lockstep with the tracer; an operand only launches on the 5->0 edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase     <= 3'd0;
         pend      <= 1'b0;
         pend_abs  <= 1'b0;
         pend_data <= 16'h0000;
         active    <= 1'b0;
         shift     <= 16'h0000;
         t_data    <= 4'h0;
         t_abs     <= 1'b0;
      end else begin
         phase <= frame_start ? 3'd0 : phase + 3'd1;

         if (in_valid && !pend) begin
            pend      <= 1'b1;
            pend_data <= in_data;
            pend_abs  <= in_abs;
         end

         if (frame_start) begin
            active <= pend;
            t_abs  <= pend && pend_abs;
            if (pend) begin
               pend   <= 1'b0;
               t_data <= pend_data[15:12];
               shift  <= {pend_data[11:0], 4'h0};
            end else begin
               t_data <= 4'h0;
               shift  <= 16'h0000;
            end
         end else if (active && (phase < 3'd3)) begin
            t_data <= shift[15:12];
            shift  <= {shift[11:0], 4'h0};
         end else begin
            t_data <= 4'h0;
         end
      end
   end

`ifdef TRACER_HOST_SYNC_EN
   logic [7:0] t_q;
   logic       frame_act;

   // Everything from the pins arrives one cycle late, so capture slides one phase and
   // the ending frame's active flag is held until hi is taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         t_q       <= 8'h00;
         frame_act <= 1'b0;
         lo        <= 8'h00;
         hi        <= 8'h00;
         done      <= 1'b0;
      end else begin
         t_q <= t_in;
         if (phase == 3'd5) begin
            lo        <= t_q;
            frame_act <= active;
         end
         if (phase == 3'd0) begin
            hi <= t_q;
         end
         done <= (phase == 3'd0) && frame_act;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         lo   <= 8'h00;
         hi   <= 8'h00;
         done <= 1'b0;
      end else begin
         if (phase == 3'd4) begin
            lo <= t_in;
         end
         if (phase == 3'd5) begin
            hi <= t_in;
         end
         done <= (phase == 3'd5) && active;
      end
   end
`endif

endmodule

// File: tb/tb_tracer_host.sv
// Bench for tracer_host: behavioural reciprocal tracer on the pins plus a scoreboard of expected results and arrival cycles.
module tb_tracer_host;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'h0000;
   logic        in_abs = 1'b0;
   logic        res_valid;
   logic [15:0] res_data;
   logic        t_reset;
   logic        t_abs;
   logic [3:0]  t_data;
   logic [7:0]  t_in;

   tracer_host dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_abs(in_abs),
      .res_valid(res_valid), .res_data(res_data),
      .t_reset(t_reset), .t_abs(t_abs), .t_data(t_data), .t_in(t_in)
   );

   always #5 clk = ~clk;

`ifdef TRACER_HOST_SYNC_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 6;
`endif

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference reciprocal in Q6.10: 2^20 / x, optional abs on the operand.
   function automatic logic [15:0] recip(input logic [15:0] v, input logic a);
      int x;
      int r;
      x = $signed(v);
      if (a && x < 0) x = -x;
      if (x == 0) return 16'h7fff;
      r = 1048576 / x;
      return r[15:0];
   endfunction

   // Tracer pin model.
   logic [2:0]  t_step = 3'd0;
   logic [15:0] t_sr = 16'h0000;
   logic [15:0] t_res;
   assign t_res = recip(t_sr, t_abs);
   assign t_in  = (t_step == 3'd4) ? t_res[7:0] : (t_step == 3'd5) ? t_res[15:8] : 8'h00;

   always @(posedge clk) begin
      if (t_reset) begin
         t_step <= 3'd0;
      end else begin
         t_step <= (t_step == 3'd5) ? 3'd0 : t_step + 3'd1;
         if (t_step < 3'd4) t_sr <= {t_sr[11:0], t_data};
      end
   end

   // Host-side reference: pending buffer and frame starts, pushing expectations.
   typedef struct {
      logic [15:0] d;
      int          c;
   } exp_t;

   exp_t        sb[$];
   int          rc_q[$];
   exp_t        e_pop;
   logic        m_pend = 1'b0;
   logic [15:0] m_d = 16'h0000;
   logic        m_a = 1'b0;
   int          cyc = 0;
   int          fs_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         m_pend <= 1'b0;
         sb.delete();
      end else begin
         if (t_step == 3'd5 && m_pend) begin
            sb.push_back('{d: recip(m_d, m_a), c: cyc + 1 + LAT});
            m_pend <= 1'b0;
            fs_cnt <= fs_cnt + 1;
         end
         if (in_valid && !m_pend) begin
            m_pend <= 1'b1;
            m_d    <= in_data;
            m_a    <= in_abs;
         end
      end
   end

   always @(negedge clk) begin
      if (res_valid) begin
         if (sb.size() == 0) begin
            check("spurious_res_valid", 32'd1, 32'd0);
         end else begin
            e_pop = sb.pop_front();
            check("res_data", {16'h0, res_data}, {16'h0, e_pop.d});
            check("res_cycle", cyc, e_pop.c);
            rc_q.push_back(cyc);
         end
      end
   end

   // All tasks are entered and left on a falling edge.
   task automatic send(input logic [15:0] d, input logic a);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", {31'h0, in_ready}, 32'd1);
      check("in_ready_vs_pend", {31'h0, in_ready}, {31'h0, !m_pend});
      in_valid = 1'b1;
      in_data  = d;
      in_abs   = a;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_frame();
      int f0 = fs_cnt;
      int n = 0;
      while (fs_cnt == f0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("frame_start_seen", {31'h0, fs_cnt != f0}, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", sb.size(), 32'd0);
      repeat (8) @(negedge clk);
   endtask

   logic [3:0] nib [6];

   initial begin
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'h0, in_ready}, 32'd1);
      check("rst_res_valid", {31'h0, res_valid}, 32'd0);
      check("rst_res_data", {16'h0, res_data}, 32'd0);
      check("rst_t_data", {28'h0, t_data}, 32'd0);
      check("rst_t_abs", {31'h0, t_abs}, 32'd0);
      check("rst_t_reset", {31'h0, t_reset}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("t_reset_released", {31'h0, t_reset}, 32'd0);

      // Nibble order, MSB first, then zeros in the capture phases.
      nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0};
      send(16'h1234, 1'b0);
      wait_frame();
      for (int i = 0; i < 6; i++) begin
         check($sformatf("nibble_p%0d", i), {28'h0, t_data}, {28'h0, nib[i]});
         check($sformatf("abs_low_p%0d", i), {31'h0, t_abs}, 32'd0);
         @(negedge clk);
      end
      drain();

      // Loopback values.
      send(16'h0400, 1'b0);
      drain();
      send(16'h0800, 1'b0);
      drain();
      send(16'h0200, 1'b0);
      drain();

      // Back-to-back frames.
      rc_q.delete();
      send(16'h0300, 1'b0);
      send(16'h0A00, 1'b0);
      send(16'h1000, 1'b0);
      drain();
      check("b2b_count", rc_q.size(), 32'd3);
      if (rc_q.size() == 3) begin
         check("b2b_gap0", rc_q[1] - rc_q[0], 32'd6);
         check("b2b_gap1", rc_q[2] - rc_q[1], 32'd6);
      end

      // Abs mode held across all six phases.
      send(16'hFC00, 1'b1);
      wait_frame();
      for (int i = 0; i < 6; i++) begin
         check($sformatf("abs_high_p%0d", i), {31'h0, t_abs}, 32'd1);
         @(negedge clk);
      end
      drain();
      send(16'hFC00, 1'b0);
      drain();

      // Reset in phase 2 of an active frame with a second operand pending.
      send(16'h0400, 1'b0);
      wait_frame();
      send(16'h0800, 1'b0);
      for (int n = 0; n < 10 && t_step != 3'd2; n++) @(negedge clk);
      check("reached_phase2", {29'h0, t_step}, 32'd2);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_t_reset", {31'h0, t_reset}, 32'd1);
      check("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
      check("mid_rst_t_data", {28'h0, t_data}, 32'd0);
      check("mid_rst_res_valid", {31'h0, res_valid}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("idle_t_data_p%0d", i), {28'h0, t_data}, 32'd0);
         check($sformatf("idle_in_ready_p%0d", i), {31'h0, in_ready}, 32'd1);
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      send(16'h0200, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tracer_host.md
# tracer_host

Host-side initiator for the nibble-serial reciprocal tracer port. It accepts a 16-bit Q6.10 operand over a valid/ready handshake and drives it to the tracer as four nibbles, MSB first. It then captures the two result bytes the tracer presents and returns the reassembled 16-bit Q6.10 reciprocal. It sits between the raybox-side pipeline, or a bench, and the 8-bit tracer pins, and keeps a mirrored copy of the tracer's 6-step frame counter.

## Interface
- No parameters.
- clk  in  1  clock; also drives the tracer clock pin.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high when the pending buffer is empty.
- in_data  in  16  Q6.10 operand.
- in_abs  in  1  abs mode for this operand.
- res_valid  out  1  one-cycle pulse; res_data is valid.
- res_data  out  16  Q6.10 result, {high byte, low byte}.
- t_reset  out  1  tracer reset; combinationally equal to reset.
- t_abs  out  1  tracer abs pin.
- t_data  out  4  tracer nibble pin (io_in[7:4]).
- t_in  in  8  tracer output byte (io_out).

## Operation
- phase (3 bits) mirrors the tracer step: 0 on reset, then 0→1→2→3→4→5→0 every cycle. It is never held.
- Tracer behaviour relied on:
  - At the end of phases 0-3 the tracer shifts in t_data.
  - During phase 4, t_in is result bits [7:0].
  - During phase 5, t_in is result bits [15:8].
- Pending buffer: pend flag plus operand and abs registers. A transfer occurs when in_valid and in_ready are both high; it sets pend. in_ready = !pend.
- Frame start happens on the edge where phase goes 5→0.
  - If pend is set: active<=1, shift<=in operand, t_abs<=buffered abs, pend<=0.
  - Otherwise: active<=0 (idle frame).
- t_data is registered. On the edge entering phase p (p=0..3) it loads nibble p, where nibble 0 = operand[15:12] and nibble 3 = operand[3:0]. On the edges entering phases 4 and 5, t_data<=0. In idle frames t_data stays 0.
- t_abs holds its value for the whole frame, including phases 4 and 5.
- Capture, in the default build:
  - On the edge ending phase 4, lo<=t_in.
  - On the edge ending phase 5, hi<=t_in, and done<=active (the value of active for the frame that is ending).
  - res_valid=done for one cycle, and res_data={hi,lo}.
- There is no result backpressure. The consumer must take res_data in the cycle res_valid is high.
- Reset values: phase=0, pend=0, active=0, t_data=0, t_abs=0, res_valid=0, res_data=0, in_ready=1 (after the first edge).
- Reset mid-frame aborts the frame. No res_valid is produced for it. The buffered operand is discarded.
- An accept in the same cycle as the 5→0 edge is allowed only when pend=0 at that edge. The new operand waits for the next frame, because accept and frame start are evaluated on the same edge using pre-edge pend.

## Timing
- The first frame after reset is always idle.
- Latency, default build: frame-start edge → res_valid high 6 cycles later (during phase 0 of the next frame).
- Accept → frame start: 1-6 cycles, depending on phase at accept.
- Throughput: one operand per 6 cycles. Back-to-back frames require in_valid to be reasserted while pend=0 before each 5→0 edge.
- t_reset has zero latency, so the tracer and host phase leave reset on the same edge.

## Configuration
- TRACER_HOST_SYNC_EN: adds a one-stage input register t_q<=t_in, to tolerate pad/board delay.
  - Defined: lo is captured from t_q on the edge ending phase 5. hi and done are captured on the edge ending phase 0 of the following frame. res_valid rises during phase 1 (latency 7).
  - Undefined: capture is direct from t_in as described above (latency 6).
- Phase sequencing and t_data timing are identical in both builds.

## Test plan
- Nibble order: accept 0x1234, abs=0 → t_data = 1,2,3,4 during phases 0-3 of the next frame, then 0.
- Loopback with the real tracer, operand 0x0400 (1.0), abs=0 → one res_valid with res_data=0x0400, exactly 6 cycles after frame start (7 with TRACER_HOST_SYNC_EN).
- Loopback with operands 0x0800 and 0x0200 → res_data 0x0200 and 0x0800 respectively.
- Back-to-back: three operands accepted ahead of consecutive frame starts → three res_valid pulses spaced exactly 6 cycles apart, in order. No pulses for idle frames.
- Reset asserted during phase 2 of an active frame, with a second operand pending → no res_valid is produced. After release: phase=0, in_ready=1, and the first frame is idle.
- Abs: operand 0xFC00 (-1.0) with abs=1 → t_abs high for all 6 phases, and res_data matches the tracer's abs-mode result for +1.0.
